fft_frame_controller: RTL and testbench

- Sequences one Doppler FFT frame at a time: gathers FFT_SIZE echo samples, streams them into the pipelined FFT core, then keeps the core running with zero samples until the frame's bins come out.
- Scans the positive-frequency bins for the largest magnitude. Reports that bin index to the doppler_velocity stage with a one-cycle start pulse.
- Sits between the echo detector/receiver path and fftmain + doppler_velocity, replacing ad-hoc ce gating and peak tracking.

---
 rtl/fft_frame_controller.sv | 207 ++++++++++++++++++++
 tb/tb_fft_frame_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_controller.sv
// fft_frame_controller
// Sequences one Doppler FFT frame at a time. It collects FFT_SIZE receiver
// samples and streams them into the pipelined FFT core. It then keeps the core
// clocked with zero samples until bin 0 appears. Positive-frequency bins
// 1..FFT_SIZE/2-1 are scanned for the largest magnitude, and the winning bin
// is handed to doppler_velocity with a one-cycle calc_start pulse.
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous active-high reset (shared with the FFT core)
//   frame_start   capture request, honoured only in IDLE
//   sample_valid  receiver sample present
//   sample_data   signed 16-bit receiver sample
//   sample_ready  high in FILL; sample accepted on valid & ready
//   fft_ce        registered clock enable to the FFT core
//   fft_sample    registered {real, imag} sample to the FFT core
//   fft_result    FFT core output {real[31:16], imag[15:0]}, signed
//   fft_sync      FFT core bin-0 marker, meaningful only while fft_ce is high
//   calc_start    one-cycle start pulse to doppler_velocity
//   peak_bin      index of the largest candidate bin of the last reported frame
//   peak_mag      magnitude re*re + im*im of peak_bin
//   busy          high in every state except IDLE
//   timeout_err   one-cycle pulse when no sync is seen within SYNC_TIMEOUT cycles
//
// state  | meaning
// IDLE   | waiting for frame_start
// FILL   | accepting FFT_SIZE samples, one core ce per accepted sample
// FLUSH  | clocking zeros into the core until fft_sync marks bin 0
// SCAN   | walking bins 1..FFT_SIZE-1, tracking the largest candidate
// REPORT | publishing peak_bin/peak_mag and pulsing calc_start
module fft_frame_controller #(
    parameter int FFT_SIZE     = 1024,
    parameter int LOG2_SIZE    = 10,
    parameter int SYNC_TIMEOUT = 4096
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 frame_start,
    input  logic                 sample_valid,
    input  logic [15:0]          sample_data,
    output logic                 sample_ready,
    output logic                 fft_ce,
    output logic [31:0]          fft_sample,
    input  logic [31:0]          fft_result,
    input  logic                 fft_sync,
    output logic                 calc_start,
    output logic [LOG2_SIZE-1:0] peak_bin,
    output logic [31:0]          peak_mag,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int CNT_W = LOG2_SIZE + 1;
    localparam int TMO_W = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_SIZE - 1);
    localparam logic [CNT_W-1:0] HALF_IDX = CNT_W'(FFT_SIZE / 2);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(SYNC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FLUSH,
        S_SCAN,
        S_REPORT
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]     sample_cnt;
    logic [CNT_W-1:0]     bin_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [31:0]          max_mag;
    logic [LOG2_SIZE-1:0] max_bin;

    logic accept;
    logic sync_seen;
    logic tmo_hit;
    logic candidate;

    logic signed [15:0] res_re;
    logic signed [15:0] res_im;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;
    logic [31:0]        mag;

    // Each square is at most 2^30, so the unsigned sum peaks at 2^31 without wrapping.
    assign res_re = signed'(fft_result[31:16]);
    assign res_im = signed'(fft_result[15:0]);
    assign re_sq  = res_re * res_re;
    assign im_sq  = res_im * res_im;
    assign mag    = $unsigned(re_sq) + $unsigned(im_sq);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        sync_seen    = 1'b0;
        tmo_hit      = 1'b0;
        sample_ready = 1'b0;
        busy         = 1'b1;
        candidate    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                sample_ready = 1'b1;
                accept       = sample_valid;
                if (sample_valid && sample_cnt == LAST_IDX) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fft_ce && fft_sync) begin
                    sync_seen = 1'b1;
                    state_nxt = S_SCAN;
                end else if (tmo_cnt == '0) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                // bin_cnt never holds 0 here, so only the upper bound needs checking.
                candidate = fft_ce && (bin_cnt < HALF_IDX);
                if (bin_cnt == LAST_IDX) begin
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fft_ce      <= 1'b0;
            fft_sample  <= '0;
            calc_start  <= 1'b0;
            timeout_err <= 1'b0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            sample_cnt  <= '0;
            bin_cnt     <= '0;
            tmo_cnt     <= '0;
            max_mag     <= '0;
            max_bin     <= '0;
        end else begin
            // The core keeps running through FLUSH and SCAN. The first FLUSH
            // cycle carries the last accepted sample.
            fft_ce      <= accept || (state_nxt == S_FLUSH) || (state_nxt == S_SCAN);
            fft_sample  <= accept ? {sample_data, 16'h0000} : 32'h0000_0000;
            calc_start  <= (state == S_REPORT);
            timeout_err <= tmo_hit;

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        sample_cnt <= '0;
                        bin_cnt    <= '0;
                        max_mag    <= '0;
                        max_bin    <= LOG2_SIZE'(1);
                    end
                end
                S_FILL: begin
                    tmo_cnt <= TMO_LOAD;
                    if (accept) begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (sync_seen) begin
                        bin_cnt <= CNT_W'(1);
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                S_SCAN: begin
                    bin_cnt <= bin_cnt + 1'b1;
                    // A strict compare lets the lowest bin win a tie.
                    if (candidate && mag > max_mag) begin
                        max_mag <= mag;
                        max_bin <= bin_cnt[LOG2_SIZE-1:0];
                    end
                end
                S_REPORT: begin
                    peak_bin <= max_bin;
                    peak_mag <= max_mag;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_controller.sv
module tb_fft_frame_controller;
    localparam int FFT_SIZE = 1024;
    localparam int LOG2_SIZE = 10;
    localparam int SYNC_TIMEOUT = 4096;
    localparam int LAT = FFT_SIZE + 5;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 frame_start;
    logic                 sample_valid;
    logic [15:0]          sample_data;
    logic                 sample_ready;
    logic                 fft_ce;
    logic [31:0]          fft_sample;
    logic [31:0]          fft_result;
    logic                 fft_sync;
    logic                 calc_start;
    logic [LOG2_SIZE-1:0] peak_bin;
    logic [31:0]          peak_mag;
    logic                 busy;
    logic                 timeout_err;

    fft_frame_controller #(
        .FFT_SIZE    (FFT_SIZE),
        .LOG2_SIZE   (LOG2_SIZE),
        .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .frame_start (frame_start),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .sample_ready(sample_ready),
        .fft_ce      (fft_ce),
        .fft_sample  (fft_sample),
        .fft_result  (fft_result),
        .fft_sync    (fft_sync),
        .calc_start  (calc_start),
        .peak_bin    (peak_bin),
        .peak_mag    (peak_mag),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [LOG2_SIZE-1:0] bin;
        logic [31:0]          mag;
    } result_t;
    result_t sb[$];

    // Stub FFT core: bin k of the frame appears on ce cycle LAT+k.
    logic signed [15:0] bin_re [FFT_SIZE];
    logic signed [15:0] bin_im [FFT_SIZE];
    logic stub_clr = 1'b0;
    logic sync_en  = 1'b1;
    int   ce_cnt;
    int   stub_idx;

    always @(posedge clk_in) begin
        if (rst_in || stub_clr) ce_cnt <= 0;
        else if (fft_ce) ce_cnt <= ce_cnt + 1;
    end

    always_comb begin
        stub_idx   = 0;
        fft_sync   = 1'b0;
        fft_result = 32'h0;
        if (fft_ce && sync_en && ce_cnt >= LAT) begin
            stub_idx   = (ce_cnt - LAT) % FFT_SIZE;
            fft_sync   = (stub_idx == 0);
            fft_result = {bin_re[stub_idx], bin_im[stub_idx]};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (calc_start === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_calc_start: observed=1 expected=0");
            end
            if (sb.size() > 0) begin
                result_t r;
                r = sb.pop_front();
                check("peak_bin", peak_bin, r.bin);
                check("peak_mag", peak_mag, r.mag);
                check("busy_at_calc", busy, 0);
            end
        end
    end

    task automatic clear_bins();
        foreach (bin_re[i]) begin
            bin_re[i] = 16'sd0;
            bin_im[i] = 16'sd0;
        end
    endtask

    task automatic push_exp(input int b, input logic [31:0] m);
        result_t r;
        r.bin = LOG2_SIZE'(b);
        r.mag = m;
        sb.push_back(r);
    endtask

    // Starts a frame and feeds FFT_SIZE samples; returns at the first FLUSH cycle.
    task automatic drive_frame(input bit gaps, input bit fs_mid);
        int   acc = 0;
        int   cyc = 0;
        int   mism = 0;
        int   pulses = 0;
        logic v;
        logic [15:0] d;
        frame_start = 1'b1;
        stub_clr    = 1'b1;
        @(negedge clk_in);
        frame_start = 1'b0;
        stub_clr    = 1'b0;
        while (acc < FFT_SIZE) begin
            v = gaps ? (cyc % 3 == 0) : 1'b1;
            d = 16'($urandom);
            sample_valid = v;
            sample_data  = d;
            frame_start  = fs_mid && (cyc == 10);
            if (sample_ready !== 1'b1) mism++;
            @(negedge clk_in);
            if (fft_ce !== v) mism++;
            if (fft_sample !== (v ? {d, 16'h0000} : 32'h0)) mism++;
            if (fft_ce === 1'b1) pulses++;
            if (v) acc++;
            cyc++;
        end
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        check("fill_ce_pattern", mism, 0);
        check("fill_ce_pulses", pulses, FFT_SIZE);
    endtask

    task automatic wait_result();
        for (int i = 0; i < 6000 && sb.size() != 0; i++) @(negedge clk_in);
        check("result_arrived", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in       = 1'b1;
        frame_start  = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 16'h0;
        clear_bins();
        repeat (3) @(negedge clk_in);
        check("rst_sample_ready", sample_ready, 0);
        check("rst_fft_ce", fft_ce, 0);
        check("rst_fft_sample", fft_sample, 0);
        check("rst_calc_start", calc_start, 0);
        check("rst_peak_bin", peak_bin, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Tone at bin 37, contiguous samples.
        clear_bins();
        bin_re[37] = 16'sd1000;
        push_exp(37, 32'd1_000_000);
        drive_frame(1'b0, 1'b0);
        wait_result();

        // Same tone with sample_valid on a 1-in-3 pattern.
        push_exp(37, 32'd1_000_000);
        drive_frame(1'b1, 1'b0);
        wait_result();

        // Tie at bins 5 and 9, DC and bin 700 excluded.
        clear_bins();
        bin_re[0]   = 16'sd30000;
        bin_re[5]   = 16'sd12;
        bin_im[5]   = 16'sd16;
        bin_re[9]   = 16'sd20;
        bin_re[700] = 16'sd5000;
        push_exp(5, 32'd400);
        drive_frame(1'b0, 1'b0);
        wait_result();

        // No sync: timeout after SYNC_TIMEOUT FLUSH cycles, peak held.
        sync_en = 1'b0;
        drive_frame(1'b0, 1'b0);
        repeat (SYNC_TIMEOUT - 1) @(negedge clk_in);
        check("tmo_not_early", timeout_err, 0);
        check("tmo_busy_before", busy, 1);
        @(negedge clk_in);
        check("tmo_pulse", timeout_err, 1);
        check("tmo_busy_after", busy, 0);
        check("tmo_peak_bin_held", peak_bin, 5);
        check("tmo_peak_mag_held", peak_mag, 400);
        @(negedge clk_in);
        check("tmo_one_cycle", timeout_err, 0);
        sync_en = 1'b1;
        repeat (2) @(negedge clk_in);

        // Last candidate bin 511 wins; bin 512 is out of range.
        clear_bins();
        bin_re[511] = 16'sd1;
        bin_re[512] = 16'sd10000;
        push_exp(511, 32'd1);
        drive_frame(1'b0, 1'b0);
        wait_result();

        // All-zero spectrum reports bin 1 with magnitude 0.
        clear_bins();
        push_exp(1, 32'd0);
        drive_frame(1'b0, 1'b0);
        wait_result();

        // Full-scale negative input at bin 3.
        clear_bins();
        bin_re[3] = -16'sd32768;
        bin_im[3] = -16'sd32768;
        push_exp(3, 32'h8000_0000);
        drive_frame(1'b0, 1'b0);
        wait_result();

        // Reset during SCAN discards the frame.
        clear_bins();
        bin_re[37] = 16'sd1000;
        drive_frame(1'b0, 1'b0);
        repeat (200) @(negedge clk_in);
        check("abort_busy_mid_scan", busy, 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("abort_fft_ce", fft_ce, 0);
        check("abort_peak_bin", peak_bin, 0);
        check("abort_peak_mag", peak_mag, 0);
        check("abort_busy", busy, 0);
        check("abort_calc_start", calc_start, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (1100) @(negedge clk_in);

        // Fresh frame after reset, frame_start pulsed during FILL.
        clear_bins();
        bin_re[100] = -16'sd300;
        bin_im[100] = 16'sd400;
        bin_re[200] = 16'sd100;
        push_exp(100, 32'd250_000);
        drive_frame(1'b0, 1'b1);
        wait_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
